// File: rtl/regfile_pkg.sv
// Shared constants and arbiter state encoding for the register-file write path.
package regfile_pkg;

   localparam int            DATA_W         = 32;
   localparam int            ADDR_W         = 5;
   localparam logic [4:0]    REG_ZERO       = 5'd0;
   localparam int            STARVE_MAX_DEF = 3;
   localparam int            STARVE_CNT_W   = 4;

   typedef enum logic {
      ARB_NORMAL  = 1'b0,
      ARB_FORCE_B = 1'b1
   } arb_state_e;

endpackage

// File: rtl/wr_starve_ctr.sv
// Saturating count of consecutive cycles the multi-cycle unit was denied the port.
module wr_starve_ctr
   import regfile_pkg::*;
#(
   parameter int MAX   = STARVE_MAX_DEF,
   parameter int CNT_W = STARVE_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != CNT_W'(MAX)))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Looks at the next value so the FSM switches on the same edge the count saturates.
   assign hit = (cnt_d == CNT_W'(MAX));

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (A, priority) and the
// multi-cycle unit (B), with a starvation guard that forces one B grant.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W     = regfile_pkg::DATA_W,
   parameter int ADDR_W     = regfile_pkg::ADDR_W,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              regwrite,
   output logic [ADDR_W-1:0] writereg,
   output logic [DATA_W-1:0] writedata,
   output logic              force_b
);

   arb_state_e        state_q, state_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] writereg_q, writereg_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;

   logic a_nz, b_nz;
   logic grant_a, grant_b;
   logic starve_inc, starve_clr, starve_hit;

   assign a_nz = a_valid && (a_addr != ADDR_W'(REG_ZERO));
   assign b_nz = b_valid && (b_addr != ADDR_W'(REG_ZERO));

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!reset) begin
         if (state_q == ARB_FORCE_B) begin
            grant_b = b_nz;
            grant_a = a_nz && !b_nz;
         end else begin
            grant_a = a_nz;
            grant_b = b_nz && !a_nz;
         end
      end
   end

   // Zero-address requests are absorbed: accepted at once, never consume the port.
   assign a_ready = !reset && ((a_valid && !a_nz) || grant_a);
   assign b_ready = !reset && ((b_valid && !b_nz) || grant_b);

   assign starve_inc = b_nz && !b_ready;
   assign starve_clr = b_ready || !b_valid;

   wr_starve_ctr #(
      .MAX   (STARVE_MAX),
      .CNT_W (STARVE_CNT_W)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .hit   (starve_hit)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_NORMAL:  if (starve_hit)         state_d = ARB_FORCE_B;
         ARB_FORCE_B: if (grant_b || !b_nz)   state_d = ARB_NORMAL;
         default:                             state_d = ARB_NORMAL;
      endcase
   end

   always_comb begin
      regwrite_d  = grant_a || grant_b;
      writereg_d  = writereg_q;
      writedata_d = writedata_q;
      if (grant_b) begin
         writereg_d  = b_addr;
         writedata_d = b_data;
      end else if (grant_a) begin
         writereg_d  = a_addr;
         writedata_d = a_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_NORMAL;
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
      end else begin
         state_q     <= state_d;
         regwrite_q  <= regwrite_d;
         writereg_q  <= writereg_d;
         writedata_q <= writedata_d;
      end
   end

   assign regwrite  = regwrite_q;
   assign writereg  = writereg_q;
   assign writedata = writedata_q;
   assign force_b   = (state_q == ARB_FORCE_B);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_valid, b_valid;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready;
   logic          regwrite;
   logic [AW-1:0] writereg;
   logic [DW-1:0] writedata;
   logic          force_b;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .STARVE_MAX (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .regwrite  (regwrite),
      .writereg  (writereg),
      .writedata (writedata),
      .force_b   (force_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      a_valid = v; a_addr = ad; a_data = d;
   endtask

   task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      b_valid = v; b_addr = ad; b_data = d;
   endtask

   initial begin
      // Reset with both requesters valid
      reset = 1'b1;
      drive_a(1'b1, 5'd1, 32'h11);
      drive_b(1'b1, 5'd2, 32'h22);
      tick();
      tick();
      chk("rst_a_ready",   32'(a_ready),   32'h0);
      chk("rst_b_ready",   32'(b_ready),   32'h0);
      chk("rst_regwrite",  32'(regwrite),  32'h0);
      chk("rst_writereg",  32'(writereg),  32'h0);
      chk("rst_writedata", writedata,      32'h0);
      chk("rst_force_b",   32'(force_b),   32'h0);

      @(negedge clk);
      reset = 1'b0;
      drive_a(1'b0, 5'd0, 32'h0);
      drive_b(1'b0, 5'd0, 32'h0);
      tick();

      // A only
      @(negedge clk);
      drive_a(1'b1, 5'd8, 32'h0000_00AA);
      #1;
      chk("aonly_a_ready", 32'(a_ready), 32'h1);
      chk("aonly_b_ready", 32'(b_ready), 32'h0);
      tick();
      chk("aonly_regwrite",  32'(regwrite), 32'h1);
      chk("aonly_writereg",  32'(writereg), 32'd8);
      chk("aonly_writedata", writedata,     32'hAA);
      @(negedge clk);
      drive_a(1'b0, 5'd0, 32'h0);
      tick();
      chk("idle_regwrite", 32'(regwrite), 32'h0);
      chk("idle_hold_reg", 32'(writereg), 32'd8);

      // Conflict: A wins, B follows
      @(negedge clk);
      drive_a(1'b1, 5'd9,  32'h1);
      drive_b(1'b1, 5'd10, 32'h2);
      #1;
      chk("conf_a_ready", 32'(a_ready), 32'h1);
      chk("conf_b_ready", 32'(b_ready), 32'h0);
      tick();
      chk("conf_w1_reg",  32'(writereg), 32'd9);
      chk("conf_w1_data", writedata,     32'h1);
      @(negedge clk);
      drive_a(1'b0, 5'd0, 32'h0);
      #1;
      chk("conf_b_ready2", 32'(b_ready), 32'h1);
      tick();
      chk("conf_w2_we",   32'(regwrite), 32'h1);
      chk("conf_w2_reg",  32'(writereg), 32'd10);
      chk("conf_w2_data", writedata,     32'h2);
      @(negedge clk);
      drive_b(1'b0, 5'd0, 32'h0);
      tick();
      chk("conf_idle_we", 32'(regwrite), 32'h0);

      // Starvation: B denied three cycles, then forced
      @(negedge clk);
      drive_a(1'b1, 5'd13, 32'h1300);
      drive_b(1'b1, 5'd12, 32'hDEAD);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("starve_b_ready_c%0d", c), 32'(b_ready), 32'h0);
         chk($sformatf("starve_force_c%0d", c),   32'(force_b), 32'h0);
         tick();
         chk($sformatf("starve_wreg_c%0d", c),    32'(writereg), 32'd13);
         @(negedge clk);
      end
      #1;
      chk("force_force_b", 32'(force_b), 32'h1);
      chk("force_b_ready", 32'(b_ready), 32'h1);
      chk("force_a_ready", 32'(a_ready), 32'h0);
      tick();
      chk("force_wreg",    32'(writereg), 32'd12);
      chk("force_wdata",   writedata,     32'hDEAD);
      chk("force_back",    32'(force_b),  32'h0);
      @(negedge clk);
      drive_b(1'b0, 5'd0, 32'h0);
      #1;
      chk("post_a_ready", 32'(a_ready), 32'h1);
      tick();
      chk("post_wreg", 32'(writereg), 32'd13);
      @(negedge clk);
      drive_a(1'b0, 5'd0, 32'h0);
      tick();

      // Zero address on A alongside a real B write
      @(negedge clk);
      drive_a(1'b1, 5'd0, 32'hFFFF);
      drive_b(1'b1, 5'd3, 32'h5);
      #1;
      chk("zero_a_ready", 32'(a_ready), 32'h1);
      chk("zero_b_ready", 32'(b_ready), 32'h1);
      tick();
      chk("zero_we",    32'(regwrite), 32'h1);
      chk("zero_wreg",  32'(writereg), 32'd3);
      chk("zero_wdata", writedata,     32'h5);

      // Both zero: accepted, no write
      @(negedge clk);
      drive_a(1'b1, 5'd0, 32'h1234);
      drive_b(1'b1, 5'd0, 32'h5678);
      #1;
      chk("bz_a_ready", 32'(a_ready), 32'h1);
      chk("bz_b_ready", 32'(b_ready), 32'h1);
      tick();
      chk("bz_we",    32'(regwrite), 32'h0);
      chk("bz_wreg",  32'(writereg), 32'd3);
      chk("bz_wdata", writedata,     32'h5);
      @(negedge clk);
      drive_a(1'b0, 5'd0, 32'h0);
      drive_b(1'b0, 5'd0, 32'h0);
      tick();

      // Reset lands on the edge that would have registered the A write
      @(negedge clk);
      drive_a(1'b1, 5'd7, 32'h77);
      #1;
      chk("mid_a_ready_pre", 32'(a_ready), 32'h1);
      reset = 1'b1;
      #1;
      chk("mid_a_ready_rst", 32'(a_ready), 32'h0);
      tick();
      chk("mid_we",    32'(regwrite), 32'h0);
      chk("mid_wreg",  32'(writereg), 32'h0);
      chk("mid_wdata", writedata,     32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive_a(1'b0, 5'd0, 32'h0);
      tick();
      chk("mid_after_we", 32'(regwrite), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (regwrite / writereg / writedata) between two producers in the pipelined datapath.
- Requester A is the pipeline writeback stage (high priority). Requester B is the multi-cycle unit (mult/div result or late load return).
- Fixed priority to A, with a starvation guard that forces one B grant after B has been denied STARVE_MAX consecutive cycles.
- The write port is registered. Writes to $zero are absorbed and never reach the register file.

Parameters:
- DATA_W, 32, data width of the write port
- ADDR_W, 5, register index width (32 registers)
- STARVE_MAX, 3, consecutive B denials that trigger a forced B grant; legal range 1..15

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- a_valid  input  1  writeback stage has a result
- a_addr  input  ADDR_W  destination register for A
- a_data  input  DATA_W  result data for A
- a_ready  output  1  A accepted this cycle
- b_valid  input  1  multi-cycle unit has a result
- b_addr  input  ADDR_W  destination register for B
- b_data  input  DATA_W  result data for B
- b_ready  output  1  B accepted this cycle
- regwrite  output  1  register-file write enable (registered)
- writereg  output  ADDR_W  register-file write index (registered)
- writedata  output  DATA_W  register-file write data (registered)
- force_b  output  1  high while the FSM is in FORCE_B (debug/perf)

Behaviour:
- Reset (sync, active-high): regwrite=0, writereg=0, writedata=0, starve count=0, FSM=NORMAL, force_b=0. While reset is high, a_ready=b_ready=0.
- Handshake: a transfer occurs when valid && ready. Valid must not depend on ready. Ready is combinational from the FSM state, the valids and the addresses. Data and address must be held stable while valid && !ready.
- Zero-address rule: a request with addr==0 is accepted immediately (ready=1) whenever not in reset. It produces no write and does not consume the port.
- Grant, NORMAL state:
  - If a_valid and a_addr!=0: grant A.
  - Else if b_valid and b_addr!=0: grant B.
- Grant, FORCE_B state:
  - If b_valid and b_addr!=0: grant B; a_ready=0 unless a_addr==0.
  - If B drops valid (or its addr is 0): return to NORMAL the next cycle, with no forced grant carried over.
- Port output: on a grant at edge N, the edge registers regwrite=1, writereg=addr and writedata=data. With no grant at edge N, regwrite=0 and writereg/writedata hold their previous values. Latency is 1 cycle from acceptance to the regwrite pulse. Throughput is 1 write per cycle.
- Starvation counter (0..STARVE_MAX, saturating):
  - Increments when b_valid && b_addr!=0 && !b_ready.
  - Clears on a B grant or when b_valid==0.
- FSM:
  - NORMAL -> FORCE_B when the counter reaches STARVE_MAX (evaluated at the edge).
  - FORCE_B -> NORMAL on a B grant or when b_valid==0.
  - force_b = (state==FORCE_B).
- Simultaneous events:
  - A zero-address request and a B nonzero-address request: both ready in the same cycle; only B writes.
  - Both addr==0: both accepted, no write.
  - A and B targeting the same nonzero register: written in grant order, each its own cycle. No merging.
- Reset mid-operation: an in-flight registered write is discarded (regwrite=0 after reset). Requesters must re-present.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W=32, ADDR_W=5, REG_ZERO=5'd0, STARVE_MAX_DEF=3
  - arbiter state encoding ARB_NORMAL=1'b0, ARB_FORCE_B=1'b1
- One sub-module is natural: wr_starve_ctr, the saturating denial counter with inc/clr inputs and a hit output.

Test Plan:
- Reset: assert reset for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, regwrite=0, writereg=0, writedata=0.
- A only: a_valid=1, a_addr=5'd8, a_data=32'h0000_00AA -> a_ready=1; next cycle regwrite=1, writereg=8, writedata=32'hAA; following idle cycle regwrite=0.
- Conflict: A={9, 32'h1} and B={10, 32'h2} both valid in cycle 0 -> A granted, B granted cycle 1; regwrite pulses write reg 9 (cycle 1), then reg 10 (cycle 2).
- Starvation (STARVE_MAX=3): A issues nonzero writes every cycle and B stays valid with {12, 32'hDEAD} -> B denied cycles 0-2, force_b=1 in cycle 3, b_ready=1 and a_ready=0 in cycle 3; writereg=12 at cycle 4; FSM back to NORMAL.
- Zero address: A={0, 32'hFFFF} and B={3, 32'h5} simultaneously -> a_ready=1 and b_ready=1 in the same cycle; the only write is reg 3 = 32'h5.
- Reset mid-flight: grant A {7, 32'h77}, then assert reset on the next edge -> regwrite=0 and the write to reg 7 never appears.
